// File: rtl/sos_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// sos_cmd_scheduler
//   Shares one sos_module between N_REQ requesters. A round-robin arbiter
//   picks one requester at a time, forwards its one-hot 4-bit command to the
//   sos_module, waits for cmd_done_sig (with an optional watchdog), and then
//   enforces an idle gap before the next command is arbitrated.
//
// Ports
//   CLK            in   system clock, rising edge
//   RSTn           in   asynchronous active-low reset
//   req_sig        in   [N_REQ]   level request per requester
//   req_cmd        in   [4*N_REQ] one-hot command per requester, slice i = [4*i+3:4*i]
//   done_sig       out  [N_REQ]   1-cycle completion/abort pulse to the granted requester
//   err_sig        out  1-cycle pulse with done_sig on invalid command or timeout
//   busy_sig       out  high whenever the scheduler is not idle
//   grant_id       out  index of the current/last granted requester
//   func_en_sig    out  to sos_module, high while a command is outstanding
//   cmd_start_sig  out  to sos_module, one-hot command held through the wait
//   cmd_done_sig   in   from sos_module, completion pulse
// ---------------------------------------------------------------------------
module sos_cmd_scheduler #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 25000000,
    parameter int TIMEOUT_CYCLES = 500000000,
    parameter int CNT_W          = 29
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [N_REQ-1:0]     req_sig,
    input  logic [4*N_REQ-1:0]   req_cmd,
    output logic [N_REQ-1:0]     done_sig,
    output logic                 err_sig,
    output logic                 busy_sig,
    output logic [2:0]           grant_id,
    output logic                 func_en_sig,
    output logic [3:0]           cmd_start_sig,
    input  logic                 cmd_done_sig
);

    // A zero gap still leaves one idle cycle between commands.
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [2:0]       LAST_REQ     = 3'(N_REQ - 1);
    localparam logic [3:0]       N_REQ_W      = 4'(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         rr_ptr_reg, rr_ptr_next;
    logic [2:0]         grant_reg, grant_next;
    logic [3:0]         cmd_reg, cmd_next;
    logic [CNT_W-1:0]   timer_reg, timer_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic               err_reg, err_next;
    logic               busy_reg, busy_next;
    logic               func_en_reg, func_en_next;
    logic [3:0]         cmd_start_reg, cmd_start_next;

    // Command slices padded to eight entries so a 3-bit grant index always
    // lands on a defined entry.
    logic [3:0]         cmd_arr [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cmd_arr
            if (gi < N_REQ) begin : g_used
                assign cmd_arr[gi] = req_cmd[4*gi +: 4];
            end else begin : g_pad
                assign cmd_arr[gi] = 4'd0;
            end
        end
    endgenerate

    // Round robin: rotate the request vector so rr_ptr sits at bit 0, take
    // the lowest set bit, then rotate the offset back into a requester index.
    logic [N_REQ-1:0]   rot_req;
    logic               arb_found;
    logic [2:0]         arb_off;
    logic [3:0]         arb_sum;
    logic [2:0]         arb_grant;
    logic [N_REQ-1:0]   grant_mask;
    logic [2:0]         grant_inc;
    logic               cmd_onehot;

    assign rot_req   = N_REQ'({req_sig, req_sig} >> rr_ptr_reg);
    assign arb_sum   = {1'b0, rr_ptr_reg} + {1'b0, arb_off};
    assign arb_grant = (arb_sum >= N_REQ_W) ? 3'(arb_sum - N_REQ_W) : arb_sum[2:0];
    assign grant_inc = (grant_reg == LAST_REQ) ? 3'd0 : grant_reg + 3'd1;
    assign cmd_onehot = (cmd_reg != 4'd0) && ((cmd_reg & (cmd_reg - 4'd1)) == 4'd0);

    always_comb begin
        arb_found = 1'b0;
        arb_off   = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                arb_found = 1'b1;
                arb_off   = 3'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            grant_mask[i] = (grant_reg == 3'(i));
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 3'd0;
            grant_reg     <= 3'd0;
            cmd_reg       <= 4'd0;
            timer_reg     <= '0;
            done_reg      <= '0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            func_en_reg   <= 1'b0;
            cmd_start_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            cmd_reg       <= cmd_next;
            timer_reg     <= timer_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            busy_reg      <= busy_next;
            func_en_reg   <= func_en_next;
            cmd_start_reg <= cmd_start_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        cmd_next       = cmd_reg;
        timer_next     = timer_reg;
        done_next      = '0;
        err_next       = 1'b0;
        func_en_next   = func_en_reg;
        cmd_start_next = cmd_start_reg;

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    grant_next = arb_grant;
                    cmd_next   = cmd_arr[arb_grant];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!cmd_onehot) begin
                    done_next   = grant_mask;
                    err_next    = 1'b1;
                    rr_ptr_next = grant_inc;
                    state_next  = IDLE;
                end else begin
                    cmd_start_next = cmd_reg;
                    func_en_next   = 1'b1;
                    timer_next     = '0;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                // Completion takes precedence over the watchdog on the same cycle.
                if (cmd_done_sig ||
                    ((TIMEOUT_CYCLES != 0) && (timer_reg == TIMEOUT_LAST))) begin
                    cmd_start_next = 4'd0;
                    func_en_next   = 1'b0;
                    done_next      = grant_mask;
                    err_next       = !cmd_done_sig;
                    timer_next     = '0;
                    state_next     = GAP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            GAP: begin
                if (timer_reg == GAP_LAST) begin
                    rr_ptr_next = grant_inc;
                    timer_next  = '0;
                    state_next  = IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign done_sig      = done_reg;
    assign err_sig       = err_reg;
    assign busy_sig      = busy_reg;
    assign grant_id      = grant_reg;
    assign func_en_sig   = func_en_reg;
    assign cmd_start_sig = cmd_start_reg;

endmodule

// File: tb/tb_sos_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sos_cmd_scheduler
//   Self-checking bench for sos_cmd_scheduler (N_REQ=4, GAP=4, TIMEOUT=100).
//   A timestamp-based reference model predicts every output each cycle;
//   a vector table covers single isolated commands, hand sequences cover
//   round robin, reset abort and stray completions, and a random phase
//   exercises contention.
// ---------------------------------------------------------------------------
module tb_sos_cmd_scheduler;

    localparam int N   = 4;
    localparam int GAP = 4;
    localparam int TO  = 100;

    logic           CLK;
    logic           RSTn;
    logic [N-1:0]   req_sig;
    logic [4*N-1:0] req_cmd;
    logic [N-1:0]   done_sig;
    logic           err_sig;
    logic           busy_sig;
    logic [2:0]     grant_id;
    logic           func_en_sig;
    logic [3:0]     cmd_start_sig;
    logic           cmd_done_sig;

    sos_cmd_scheduler #(
        .N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_W(8)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .req_sig(req_sig), .req_cmd(req_cmd),
        .done_sig(done_sig), .err_sig(err_sig), .busy_sig(busy_sig),
        .grant_id(grant_id), .func_en_sig(func_en_sig),
        .cmd_start_sig(cmd_start_sig), .cmd_done_sig(cmd_done_sig)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;
    int txn_n  = 0;

    // responder / stimulus state
    int  wait_cnt   = 0;
    int  resp_delay = 0;   // 0 means the sos_module never answers
    bit  rand_mode  = 0;
    bit  force_done = 0;

    // reference model: a command is described by its grant edge and end edge
    int         cyc;
    bit         m_active, m_valid;
    int         m_grant, m_rr, m_gedge, m_eedge;
    logic [3:0] m_cmd;
    logic [3:0] e_done, e_start;
    bit         e_err, e_busy, e_fen;

    int got_order[$];
    int got_gap[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_active = 0; m_valid = 0; m_grant = 0; m_rr = 0;
        m_gedge = 0; m_eedge = 0; m_cmd = '0;
        e_done = '0; e_start = '0; e_err = 0; e_busy = 0; e_fen = 0;
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_edge();
        bit found;
        cyc++;
        e_done = '0;
        e_err  = 0;
        if (!m_active) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_sig[(m_rr + k) % N]) begin
                    found   = 1;
                    m_grant = (m_rr + k) % N;
                end
            end
            if (found) begin
                m_active = 1;
                m_cmd    = req_cmd[4*m_grant +: 4];
                m_valid  = ($countones(m_cmd) == 1);
                m_gedge  = cyc;
                m_eedge  = 0;
            end
        end else if (!m_valid) begin
            if (cyc == m_gedge + 1) begin
                e_done[m_grant] = 1'b1;
                e_err    = 1;
                m_rr     = (m_grant + 1) % N;
                m_active = 0;
            end
        end else if (m_eedge == 0) begin
            // command outstanding from edge gedge+1; done sampled from gedge+2
            if (cyc >= m_gedge + 2) begin
                if (cmd_done_sig) begin
                    m_eedge = cyc;
                    e_done[m_grant] = 1'b1;
                end else if (cyc == m_gedge + 1 + TO) begin
                    m_eedge = cyc;
                    e_done[m_grant] = 1'b1;
                    e_err = 1;
                end
            end
        end else if (cyc == m_eedge + GAP) begin
            m_active = 0;
            m_rr     = (m_grant + 1) % N;
        end
        e_busy  = m_active;
        e_fen   = m_active && m_valid && (m_eedge == 0) && (cyc >= m_gedge + 1);
        e_start = e_fen ? m_cmd : 4'd0;
    endtask

    task automatic check_cycle();
        logic [13:0] act, exp;
        act = {done_sig, err_sig, busy_sig, grant_id, func_en_sig, cmd_start_sig};
        exp = {e_done, e_err, e_busy, 3'(m_grant), e_fen, e_start};
        chk($sformatf("cycle_outputs@%0d", cyc), 32'(act), 32'(exp));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_cycle();
        if (done_sig != 0) begin
            txn_n++;
            $display("txn %0d: done=%b err=%b grant=%0d t=%0t", txn_n, done_sig, err_sig, grant_id, $time);
            req_sig = req_sig & ~done_sig;
        end
        if (func_en_sig) wait_cnt++;
        else             wait_cnt = 0;
        if (rand_mode && wait_cnt == 1) begin
            case ($urandom % 12)
                0:       resp_delay = 0;
                1:       resp_delay = 100;
                default: resp_delay = $urandom_range(1, 15);
            endcase
        end
        cmd_done_sig = force_done || (func_en_sig && resp_delay != 0 && wait_cnt == resp_delay);
        force_done   = 0;
    endtask

    task automatic reset_dut();
        RSTn = 1'b0;
        #1;
        chk("reset_outputs",
            32'({done_sig, err_sig, busy_sig, grant_id, func_en_sig, cmd_start_sig}), 32'd0);
        model_reset();
        wait_cnt = 0; cmd_done_sig = 0; force_done = 0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic wait_idle();
        int s = 0;
        while ((busy_sig || req_sig != 0) && s < 3000) begin
            step();
            s++;
        end
        chk("idle_bound", 32'(busy_sig || req_sig != 0), 32'd0);
    endtask

    task automatic collect(input int n);
        int  last_done = -1;
        int  s = 0;
        bit  prev_fen = 0;
        got_order.delete();
        got_gap.delete();
        while (got_order.size() < n && s < 1000) begin
            step();
            s++;
            if (func_en_sig && !prev_fen && last_done >= 0) begin
                got_gap.push_back(s - last_done);
                last_done = -1;
            end
            prev_fen = func_en_sig;
            if (done_sig != 0) begin
                for (int i = 0; i < N; i++) if (done_sig[i]) got_order.push_back(i);
                last_done = s;
            end
        end
        chk("collect_bound", 32'(got_order.size()), 32'(n));
    endtask

    function automatic int order_at(input int k);
        return (k < got_order.size()) ? got_order[k] : -1;
    endfunction

    function automatic int gap_at(input int k);
        return (k < got_gap.size()) ? got_gap[k] : -1;
    endfunction

    typedef struct {
        int         idx;
        logic [3:0] cmd;
        int         delay;
        int         exp_start;  // steps from request to func_en (0: never)
        int         exp_done;   // steps from request to done_sig
        logic       exp_err;
        int         exp_gap;    // steps from done_sig until busy drops
    } vec_t;

    vec_t vecs[7];

    initial begin
        int start_step, done_step, gap, dones;
        logic [3:0] done_val;
        logic       err_val;

        vecs[0] = '{0, 4'b0001, 10,  2, 12,  1'b0, 4};
        vecs[1] = '{1, 4'b0100, 0,   2, 102, 1'b1, 4};   // watchdog
        vecs[2] = '{2, 4'b0011, 0,   0, 2,   1'b1, 0};   // two bits set
        vecs[3] = '{3, 4'b1000, 1,   2, 3,   1'b0, 4};
        vecs[4] = '{1, 4'b0000, 5,   0, 2,   1'b1, 0};   // empty command
        vecs[5] = '{2, 4'b0010, 100, 2, 102, 1'b0, 4};   // done on watchdog terminal cycle
        vecs[6] = '{0, 4'b0100, 99,  2, 101, 1'b0, 4};

        RSTn = 1'b0; req_sig = '0; req_cmd = '0; cmd_done_sig = 1'b0;
        reset_dut();

        // ---- single-command vectors ----
        for (int r = 0; r < 7; r++) begin
            wait_idle();
            req_cmd[4*vecs[r].idx +: 4] = vecs[r].cmd;
            resp_delay = vecs[r].delay;
            req_sig[vecs[r].idx] = 1'b1;
            start_step = 0; done_step = 0; done_val = '0; err_val = 0; gap = -1;
            for (int s = 1; s <= 300; s++) begin
                step();
                if (func_en_sig && start_step == 0) start_step = s;
                if (done_sig != 0 && done_step == 0) begin
                    done_step = s; done_val = done_sig; err_val = err_sig;
                end
                if (done_step != 0 && !busy_sig) begin
                    gap = s - done_step;
                    break;
                end
            end
            chk($sformatf("vec%0d_start", r), 32'(start_step), 32'(vecs[r].exp_start));
            chk($sformatf("vec%0d_done_step", r), 32'(done_step), 32'(vecs[r].exp_done));
            chk($sformatf("vec%0d_done_val", r), 32'(done_val), 32'(4'b0001 << vecs[r].idx));
            chk($sformatf("vec%0d_err", r), 32'(err_val), 32'(vecs[r].exp_err));
            chk($sformatf("vec%0d_gap", r), 32'(gap), 32'(vecs[r].exp_gap));
        end

        // ---- round robin from rr_ptr=0 ----
        wait_idle();
        reset_dut();
        req_cmd = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        resp_delay = 3;
        req_sig = 4'b0111;
        collect(3);
        for (int k = 0; k < 3; k++) chk($sformatf("rr_a_order%0d", k), 32'(order_at(k)), 32'(k));
        for (int k = 0; k < 2; k++) chk($sformatf("rr_a_gap%0d", k), 32'(gap_at(k)), 32'd6);
        req_sig = 4'b1001;
        collect(2);
        chk("rr_b_order0", 32'(order_at(0)), 32'd3);
        chk("rr_b_order1", 32'(order_at(1)), 32'd0);
        chk("rr_b_gap0", 32'(gap_at(0)), 32'd6);

        // ---- invalid command still advances rr_ptr ----
        wait_idle();
        req_cmd[11:8] = 4'b0011;
        req_sig = 4'b0100;
        collect(1);
        chk("inv_grant", 32'(order_at(0)), 32'd2);
        req_cmd[11:8] = 4'b0100;
        req_sig = 4'b1001;
        collect(1);
        chk("inv_next_grant", 32'(order_at(0)), 32'd3);

        // ---- stray cmd_done in IDLE and GAP ----
        wait_idle();
        force_done = 1;
        step(); step(); step();
        chk("idle_stray_busy", 32'(busy_sig), 32'd0);
        chk("idle_stray_done", 32'(done_sig), 32'd0);
        resp_delay = 2;
        req_sig = 4'b0001;
        collect(1);
        force_done = 1;
        dones = 0;
        for (int s = 0; s < 8; s++) begin
            step();
            if (done_sig != 0) dones++;
            if (s == 1) force_done = 1;
        end
        chk("gap_stray_dones", 32'(dones), 32'd0);
        chk("gap_stray_busy", 32'(busy_sig), 32'd0);

        // ---- reset during WAIT aborts, request is re-arbitrated ----
        wait_idle();
        resp_delay = 0;
        req_cmd[3:0] = 4'b0010;
        req_sig = 4'b0001;
        step(); step(); step(); step();
        chk("pre_reset_wait", 32'(func_en_sig), 32'd1);
        reset_dut();
        resp_delay = 5;
        step(); step();
        chk("reissue_start", 32'({func_en_sig, cmd_start_sig}), 32'({1'b1, 4'b0010}));
        chk("reissue_grant", 32'(grant_id), 32'd0);
        collect(1);
        chk("reissue_done", 32'(order_at(0)), 32'd0);

        // ---- random contention against the model ----
        rand_mode = 1;
        for (int s = 0; s < 3000; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_sig[i] && ($urandom % 8 == 0)) begin
                    if ($urandom % 8 == 0) req_cmd[4*i +: 4] = 4'($urandom);
                    else                   req_cmd[4*i +: 4] = 4'b0001 << ($urandom % 4);
                    req_sig[i] = 1'b1;
                end
            end
            if ($urandom % 40 == 0) force_done = 1;
            step();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
